// File: rtl/fpu_ret_collect.sv
// Retirement collector behind the three-lane FPU: packs up to three retire
// words per cycle into one in-order FIFO drained one word per cycle.
`ifdef swapedge
`define FRC_EDGE negedge
`else
`define FRC_EDGE posedge
`endif

module fpu_ret_collect #(
  parameter int DEPTH     = 16,
  parameter int STALL_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [13:0]              u1_ret,
  input  logic                     u1_ret_en,
  input  logic [13:0]              u3_ret,
  input  logic                     u3_ret_en,
  input  logic [13:0]              u5_ret,
  input  logic                     u5_ret_en,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [13:0]              out_data,
  output logic [1:0]               out_lane,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ret_stall,
  output logic                     ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HI = DEPTH - 3*STALL_LAT - 3;

  logic [15:0]   ram [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;
  logic [CW-1:0] free;
  logic [CW-1:0] count_next;
  logic [1:0]    p3;
  logic [1:0]    p5;
  logic          st1;
  logic          st3;
  logic          st5;
  logic [1:0]    n_st;
  logic [1:0]    n_en;
  logic [15:0]   head;

  // A lane's slot is the number of enabled lanes ahead of it;
  // it is stored only while that slot still fits in free space.
  always_comb begin
    pop  = out_vld & out_rdy;
    free = CW'(DEPTH) - count + CW'(pop);
    p3   = {1'b0, u1_ret_en};
    p5   = 2'(u1_ret_en) + 2'(u3_ret_en);
    st1  = u1_ret_en && (free != '0);
    st3  = u3_ret_en && (CW'(p3) < free);
    st5  = u5_ret_en && (CW'(p5) < free);
    n_st = 2'(st1) + 2'(st3) + 2'(st5);
    n_en = 2'(u1_ret_en) + 2'(u3_ret_en)
         + 2'(u5_ret_en);
    count_next = count + CW'(n_st) - CW'(pop);
  end

  always_ff @(`FRC_EDGE clk) begin
    if (st1) ram[wr_ptr] <= {2'd0, u1_ret};
    if (st3) ram[wr_ptr + PW'(p3)] <= {2'd1, u3_ret};
    if (st5) ram[wr_ptr + PW'(p5)] <= {2'd2, u5_ret};
  end

  always_ff @(`FRC_EDGE clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ret_stall <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(n_st);
      rd_ptr    <= rd_ptr + PW'(pop);
      count     <= count_next;
      ret_stall <= (count_next > CW'(HI));
      ovf       <= ovf | (n_en != n_st);
    end
  end

  always_comb begin
    out_vld  = (count != '0);
    head     = out_vld ? ram[rd_ptr] : 16'd0;
    out_lane = head[15:14];
    out_data = head[13:0];
  end

endmodule

`undef FRC_EDGE

// File: tb/tb_fpu_ret_collect.sv
// Randomized and directed bench for fpu_ret_collect against a
// queue-based reference of the collector.
module tb_fpu_ret_collect;

  localparam int DEPTH = 16;
  localparam int SL    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [13:0]   u1_ret = '0;
  logic          u1_ret_en = 1'b0;
  logic [13:0]   u3_ret = '0;
  logic          u3_ret_en = 1'b0;
  logic [13:0]   u5_ret = '0;
  logic          u5_ret_en = 1'b0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [13:0]   out_data;
  logic [1:0]    out_lane;
  logic [CW-1:0] count;
  logic          ret_stall;
  logic          ovf;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] q[$];
  bit m_ovf = 0;
  bit m_stall = 0;

  fpu_ret_collect #(.DEPTH(DEPTH), .STALL_LAT(SL)) dut (
    .clk(clk), .rst(rst),
    .u1_ret(u1_ret), .u1_ret_en(u1_ret_en),
    .u3_ret(u3_ret), .u3_ret_en(u3_ret_en),
    .u5_ret(u5_ret), .u5_ret_en(u5_ret_en),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_lane(out_lane),
    .count(count), .ret_stall(ret_stall), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_out();
    logic [15:0] h;
    h = (q.size() != 0) ? q[0] : 16'd0;
    check("vld", 32'(out_vld), 32'(q.size() != 0));
    check("count", 32'(count), 32'(q.size()));
    check("data", 32'(out_data), 32'(h[13:0]));
    check("lane", 32'(out_lane), 32'(h[15:14]));
    check("stall", 32'(ret_stall), 32'(m_stall));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic push(input logic [15:0] v);
    if (q.size() < DEPTH) q.push_back(v);
    else m_ovf = 1;
  endtask

  task automatic step(input logic [2:0] en,
                      input logic [13:0] w1,
                      input logic [13:0] w3,
                      input logic [13:0] w5,
                      input logic r);
    u1_ret_en = en[0]; u1_ret = w1;
    u3_ret_en = en[1]; u3_ret = w3;
    u5_ret_en = en[2]; u5_ret = w5;
    out_rdy = r;
    if (r && q.size() != 0) void'(q.pop_front());
    if (en[0]) push({2'd0, w1});
    if (en[1]) push({2'd1, w3});
    if (en[2]) push({2'd2, w5});
    m_stall = (q.size() > DEPTH - 3*SL - 3);
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic rstep(input int pr_en, input int pr_rdy);
    logic [2:0] en;
    for (int k = 0; k < 3; k++)
      en[k] = ($urandom_range(99) < pr_en);
    step(en, 14'($urandom), 14'($urandom),
         14'($urandom), $urandom_range(99) < pr_rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 4*DEPTH && q.size() != 0; i++)
      step(3'b000, 14'd0, 14'd0, 14'd0, 1'b1);
    check("drained", 32'(count), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_out();
    rst = 1'b0;

    // random traffic across several occupancy regimes
    for (int i = 0; i < 400; i++) rstep(60, 15);
    for (int i = 0; i < 400; i++) rstep(35, 90);
    for (int i = 0; i < 400; i++) rstep(40, 50);
    for (int i = 0; i < 400; i++) rstep(30, 100);

    // async reset mid-cycle with words queued
    drain();
    for (int i = 0; i < 5; i++)
      step(3'b001, 14'(i + 1), 14'd0, 14'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_vld", 32'(out_vld), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_stall", 32'(ret_stall), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    q.delete();
    m_ovf = 0;
    m_stall = 0;
    #1 rst = 1'b0;

    // burst ordering
    step(3'b111, 14'h001, 14'h002, 14'h003, 1'b0);
    step(3'b010, 14'h0, 14'h004, 14'h0, 1'b0);
    check("burst_cnt", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++)
      step(3'b000, 14'd0, 14'd0, 14'd0, 1'b1);
    check("burst_end", 32'(out_vld), 32'd0);

    // wrap: single words with rdy held
    for (int i = 0; i < 40; i++)
      step(3'b001, 14'(100 + i), 14'd0, 14'd0, 1'b1);
    drain();

    // full + simultaneous pop and triple push
    for (int i = 0; i < 15; i++)
      step(3'b100, 14'd0, 14'd0, 14'(i), 1'b0);
    step(3'b111, 14'h1a, 14'h3b, 14'h5c, 1'b1);
    check("full_cnt", 32'(count), 32'(DEPTH));
    check("full_ovf", 32'(ovf), 32'd1);

    // pop from empty
    drain();
    for (int i = 0; i < 5; i++)
      step(3'b000, 14'd0, 14'd0, 14'd0, 1'b1);

    // stall watermark rise and release
    for (int i = 0; i < 10; i++)
      step(3'b001, 14'(i), 14'd0, 14'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(3'b000, 14'd0, 14'd0, 14'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
